mac_stream_engine: RTL and testbench
====================================

Name: mac_stream_engine

Overview:
Streaming, parametrised successor to the fully-flattened combinational matrix MAC. It computes one LANES-wide output slice of a matrix product (activation × weight + bias) by accepting K beats over a valid/ready stream. Each beat carries one activation and a LANES-wide weight vector. After K beats the block adds bias, requantises (round, shift, saturate, optional ReLU) and presents the result on a valid/ready output. The block sits between the operand buffers and the softmax/activation stage.

Parameters:
DATA_WIDTH, 8, signed width of activation, weight and output elements
LANES, 4, parallel output columns per pass
ACC_WIDTH, 32, signed accumulator width per lane
BIAS_WIDTH, 16, signed width of each per-lane bias
K_WIDTH, 12, width of the k_len reduction-length field

Ports:
clk_p  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  pulse that begins a pass; honoured only in IDLE
k_len  in  K_WIDTH  reduction length (beats), sampled at start
shift  in  5  requantisation right-shift, sampled at start
relu_en  in  1  ReLU enable, sampled at start
bias  in  LANES*BIAS_WIDTH  signed per-lane bias (lane i at [i*BIAS_WIDTH +: BIAS_WIDTH]), sampled at start
in_valid  in  1  beat valid
in_ready  out  1  beat ready
in_act  in  DATA_WIDTH  signed activation for the beat
in_wgt  in  LANES*DATA_WIDTH  signed weights (lane i at [i*DATA_WIDTH +: DATA_WIDTH])
out_valid  out  1  result valid
out_ready  in  1  result ready
out_data  out  LANES*DATA_WIDTH  signed requantised results, same lane packing
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (asynchronous, any state): state=IDLE; accumulators, beat counter, out_data and latched config = 0; in_ready=0; out_valid=0; busy=0.
- States:
  - IDLE -> ACC on start when k_len!=0.
  - IDLE -> FIN on start when k_len==0; the result is bias-only.
  - ACC -> FIN on acceptance of beat number k_len.
  - FIN -> OUT after one cycle.
  - OUT -> IDLE on out_valid && out_ready.
- Latching: start in IDLE clears all accumulators and the counter, and latches k_len, shift, relu_en and bias.
- start outside IDLE is ignored and has no side effects.
- in_ready=1 only in ACC. A beat is accepted when in_valid && in_ready. Gaps in in_valid stall without penalty.
- On each accepted beat: acc[i] += sext(in_act * in_wgt[i]). The product is a full signed 2*DATA_WIDTH value, sign-extended to ACC_WIDTH. Accumulation wraps modulo 2^ACC_WIDTH, with no saturation in the accumulator.
- FIN computes and registers out_data for every lane:
  - s = acc + sext(bias).
  - If shift>0, r = (s + (1<<(shift-1))) >>> shift; otherwise r = s. This is round-half-up, arithmetic shift.
  - Saturate r to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
  - If relu_en, clamp negative values to 0.
- Latency: if the last beat is accepted at edge t, FIN is the cycle after t and out_valid rises at t+2. For k_len=0, start at edge t gives out_valid at t+2.
- OUT: out_valid stays high and out_data stays stable until accepted; in_ready=0.
- On output handshake: out_valid falls next cycle and state returns to IDLE. A start in that same cycle is ignored; start is honoured from the following cycle.
- out_data holds its last value in IDLE. Consumers qualify it with out_valid.

Test Plan:
1. Basic pass, k_len=3, shift=0, bias=0. Acts 2,3,4; per-beat weights lane0=1, lane1=-1, lane2=10, lane3=0 -> out_data lanes = 9, -9, 90, 0. out_valid rises 2 cycles after the 3rd accepted beat.
2. Saturation and ReLU, k_len=2, act=127 both beats. Weights lane0=127, lane1=-128 -> lane0=127 (32258 saturated), lane1=-128 (-32512 saturated). Repeat with relu_en=1 -> lane1=0.
3. Rounding and bias, k_len=1, shift=1. act=5, lane0 wgt=1 -> 3. act=-5 -> -2. lane2 wgt=0 with bias=100, shift=0 -> 100. k_len=0 with bias lane0=-7 -> -7 at start+2.
4. Backpressure: hold out_ready=0 for 5 cycles in OUT -> out_valid and out_data stable, in_ready=0. A start pulse during OUT is ignored, and the next pass result is unaffected.
5. Input gaps: k_len=4 with in_valid toggled 1,0,0,1,1,0,1 -> exactly 4 beats accumulated; result equals the gap-free run.
6. Reset mid-ACC: assert rst_n=0 after 2 of 5 beats -> all outputs 0 immediately. A new pass after release gives a result with no residue from the aborted pass.

Source files
------------

// File: rtl/mac_stream_engine.sv
// mac_stream_engine: streaming multiply-accumulate for one LANES-wide slice
// of a matrix product. K beats of (activation, weight vector) are accumulated
// per lane. Bias is then added and the sum is requantised (round, shift,
// saturate, optional ReLU). The result goes out on a valid/ready port.
module mac_stream_engine #(
  parameter int DATA_WIDTH = 8,
  parameter int LANES      = 4,
  parameter int ACC_WIDTH  = 32,
  parameter int BIAS_WIDTH = 16,
  parameter int K_WIDTH    = 12
) (
  input  logic                            clk_p,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic [K_WIDTH-1:0]              k_len,
  input  logic [4:0]                      shift,
  input  logic                            relu_en,
  input  logic [LANES*BIAS_WIDTH-1:0]     bias,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [DATA_WIDTH-1:0]           in_act,
  input  logic [LANES*DATA_WIDTH-1:0]     in_wgt,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [LANES*DATA_WIDTH-1:0]     out_data,
  output logic                            busy
);

  // Two guard bits absorb bias addition and the rounding increment without overflow.
  localparam int SUM_W = ACC_WIDTH + 2;
  localparam logic [K_WIDTH-1:0] K_ONE = K_WIDTH'(1'b1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_FIN  = 2'd2,
    ST_OUT  = 2'd3
  } state_e;

  state_e                          state_q, state_d;
  logic [K_WIDTH-1:0]              cnt_q, cnt_d;
  logic [K_WIDTH-1:0]              k_len_q, k_len_d;
  logic [4:0]                      shift_q, shift_d;
  logic                            relu_q, relu_d;
  logic [LANES*BIAS_WIDTH-1:0]     bias_q, bias_d;
  logic [ACC_WIDTH-1:0]            acc_q [LANES];
  logic [ACC_WIDTH-1:0]            acc_d [LANES];
  logic [LANES*DATA_WIDTH-1:0]     out_data_q, out_data_d;
  logic                            out_valid_q, out_valid_d;
  logic                            in_ready_q, in_ready_d;
  logic                            busy_q, busy_d;
  logic                            beat_accept_s;

  // Full signed product of one activation and one weight, sign-extended to the accumulator.
  function automatic logic [ACC_WIDTH-1:0] mac_term(
    input logic [DATA_WIDTH-1:0] act,
    input logic [DATA_WIDTH-1:0] wgt
  );
    logic signed [2*DATA_WIDTH-1:0] prod;
    prod = $signed(act) * $signed(wgt);
    return {{(ACC_WIDTH-2*DATA_WIDTH){prod[2*DATA_WIDTH-1]}}, prod};
  endfunction

  // Bias add, round-half-up arithmetic shift, saturation to DATA_WIDTH, optional ReLU.
  function automatic logic [DATA_WIDTH-1:0] requant(
    input logic [ACC_WIDTH-1:0]  acc,
    input logic [BIAS_WIDTH-1:0] b,
    input logic [4:0]            sh,
    input logic                  relu
  );
    logic signed [SUM_W-1:0] s;
    logic signed [SUM_W-1:0] rnd;
    logic signed [SUM_W-1:0] r;
    logic signed [SUM_W-1:0] max_v;
    logic signed [SUM_W-1:0] min_v;
    logic [DATA_WIDTH-1:0]   sat;
    s     = $signed({{(SUM_W-ACC_WIDTH){acc[ACC_WIDTH-1]}}, acc})
          + $signed({{(SUM_W-BIAS_WIDTH){b[BIAS_WIDTH-1]}}, b});
    max_v = $signed({{(SUM_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}});
    min_v = $signed({{(SUM_W-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}});
    if (sh != 5'd0) begin
      rnd = $signed({{(SUM_W-1){1'b0}}, 1'b1} << (sh - 5'd1));
    end else begin
      rnd = '0;
    end
    r = (s + rnd) >>> sh;
    if (r > max_v) begin
      sat = max_v[DATA_WIDTH-1:0];
    end else if (r < min_v) begin
      sat = min_v[DATA_WIDTH-1:0];
    end else begin
      sat = r[DATA_WIDTH-1:0];
    end
    if (relu && sat[DATA_WIDTH-1]) begin
      sat = '0;
    end else begin
      sat = sat;
    end
    return sat;
  endfunction

  assign beat_accept_s = in_valid && in_ready_q;

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    k_len_d    = k_len_q;
    shift_d    = shift_q;
    relu_d     = relu_q;
    bias_d     = bias_q;
    out_data_d = out_data_q;
    for (int i = 0; i < LANES; i++) begin
      acc_d[i] = acc_q[i];
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          k_len_d = k_len;
          shift_d = shift;
          relu_d  = relu_en;
          bias_d  = bias;
          cnt_d   = '0;
          for (int i = 0; i < LANES; i++) begin
            acc_d[i] = '0;
          end
          // A zero-length reduction goes straight to the bias-only result.
          if (k_len == '0) begin
            state_d = ST_FIN;
          end else begin
            state_d = ST_ACC;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACC: begin
        if (beat_accept_s) begin
          for (int i = 0; i < LANES; i++) begin
            acc_d[i] = acc_q[i] + mac_term(in_act, in_wgt[i*DATA_WIDTH +: DATA_WIDTH]);
          end
          cnt_d = cnt_q + K_ONE;
          if (cnt_q == (k_len_q - K_ONE)) begin
            state_d = ST_FIN;
          end else begin
            state_d = ST_ACC;
          end
        end else begin
          state_d = ST_ACC;
        end
      end
      ST_FIN: begin
        for (int i = 0; i < LANES; i++) begin
          out_data_d[i*DATA_WIDTH +: DATA_WIDTH] =
            requant(acc_q[i], bias_q[i*BIAS_WIDTH +: BIAS_WIDTH], shift_q, relu_q);
        end
        state_d = ST_OUT;
      end
      ST_OUT: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_OUT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    in_ready_d  = (state_d == ST_ACC);
    out_valid_d = (state_d == ST_OUT);
    busy_d      = (state_d != ST_IDLE);
  end

  // State, accumulator, config and output registers with asynchronous clear.
  always_ff @(posedge clk_p or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      k_len_q     <= '0;
      shift_q     <= '0;
      relu_q      <= 1'b0;
      bias_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      for (int i = 0; i < LANES; i++) begin
        acc_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      k_len_q     <= k_len_d;
      shift_q     <= shift_d;
      relu_q      <= relu_d;
      bias_q      <= bias_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
      for (int i = 0; i < LANES; i++) begin
        acc_q[i] <= acc_d[i];
      end
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mac_stream_engine.sv
// Directed bench for mac_stream_engine with hand-computed expected results.
module tb_mac_stream_engine;

  localparam int DW = 8;
  localparam int L  = 4;
  localparam int AW = 32;
  localparam int BW = 16;
  localparam int KW = 12;

  logic            clk_p = 1'b0;
  logic            rst_n;
  logic            start;
  logic [KW-1:0]   k_len;
  logic [4:0]      shift;
  logic            relu_en;
  logic [L*BW-1:0] bias;
  logic            in_valid;
  logic            in_ready;
  logic [DW-1:0]   in_act;
  logic [L*DW-1:0] in_wgt;
  logic            out_valid;
  logic            out_ready;
  logic [L*DW-1:0] out_data;
  logic            busy;

  int checks = 0;
  int errors = 0;

  mac_stream_engine #(
    .DATA_WIDTH(DW), .LANES(L), .ACC_WIDTH(AW), .BIAS_WIDTH(BW), .K_WIDTH(KW)
  ) dut (
    .clk_p(clk_p), .rst_n(rst_n), .start(start), .k_len(k_len), .shift(shift),
    .relu_en(relu_en), .bias(bias), .in_valid(in_valid), .in_ready(in_ready),
    .in_act(in_act), .in_wgt(in_wgt), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .busy(busy)
  );

  // Free-running clock, period 10.
  always #5 clk_p = ~clk_p;

  // Global time bound so the run can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pk8(input int l0, input int l1, input int l2, input int l3);
    return {l3[7:0], l2[7:0], l1[7:0], l0[7:0]};
  endfunction

  function automatic logic [63:0] pk16(input int l0, input int l1, input int l2, input int l3);
    return {l3[15:0], l2[15:0], l1[15:0], l0[15:0]};
  endfunction

  task automatic tick();
    @(posedge clk_p);
    #1;
  endtask

  task automatic start_pass(input int k, input int sh, input logic relu, input logic [63:0] b);
    start   = 1'b1;
    k_len   = k[KW-1:0];
    shift   = sh[4:0];
    relu_en = relu;
    bias    = b;
    tick();
    start   = 1'b0;
  endtask

  task automatic send_beat(input int act, input logic [31:0] w);
    logic rdy;
    logic done;
    done     = 1'b0;
    in_act   = act[DW-1:0];
    in_wgt   = w;
    in_valid = 1'b1;
    for (int n = 0; n < 50 && !done; n++) begin
      rdy = in_ready;
      tick();
      done = rdy;
    end
    in_valid = 1'b0;
    check_eq("beat_accepted", {63'd0, done}, 64'd1);
  endtask

  task automatic wait_out();
    for (int n = 0; n < 50 && !out_valid; n++) begin
      tick();
    end
    check_eq("out_valid_seen", {63'd0, out_valid}, 64'd1);
  endtask

  task automatic collect(input string tag, input logic [31:0] exp);
    wait_out();
    check_eq(tag, {32'd0, out_data}, {32'd0, exp});
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_eq({tag, "_vfall"}, {63'd0, out_valid}, 64'd0);
    check_eq({tag, "_idle"}, {63'd0, busy}, 64'd0);
  endtask

  logic [31:0] w_t1;
  logic [31:0] w_t5;
  logic [31:0] snap;
  int          pat [7];
  int          acts [4];
  int          idx;
  logic        rdy;

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    k_len     = '0;
    shift     = '0;
    relu_en   = 1'b0;
    bias      = '0;
    in_valid  = 1'b0;
    in_act    = '0;
    in_wgt    = '0;
    out_ready = 1'b0;
    w_t1      = pk8(1, -1, 10, 0);
    w_t5      = pk8(1, 2, -1, 3);
    pat       = '{1, 0, 0, 1, 1, 0, 1};
    acts      = '{1, 2, 3, 4};

    // Reset state
    #12;
    check_eq("rst_in_ready", {63'd0, in_ready}, 64'd0);
    check_eq("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check_eq("rst_busy", {63'd0, busy}, 64'd0);
    check_eq("rst_out_data", {32'd0, out_data}, 64'd0);
    rst_n = 1'b1;
    tick();

    // 1: basic pass and latency (valid is visible one edge after FIN, usable at t+2)
    start_pass(3, 0, 1'b0, 64'd0);
    check_eq("t1_in_ready", {63'd0, in_ready}, 64'd1);
    send_beat(2, w_t1);
    send_beat(3, w_t1);
    send_beat(4, w_t1);
    check_eq("t1_fin_valid", {63'd0, out_valid}, 64'd0);
    check_eq("t1_fin_busy", {63'd0, busy}, 64'd1);
    check_eq("t1_fin_in_ready", {63'd0, in_ready}, 64'd0);
    tick();
    check_eq("t1_out_valid", {63'd0, out_valid}, 64'd1);
    collect("t1_data", 32'h005AF709);

    // 2: saturation, then ReLU
    start_pass(2, 0, 1'b0, 64'd0);
    send_beat(127, pk8(127, -128, 0, 0));
    send_beat(127, pk8(127, -128, 0, 0));
    collect("t2_sat", 32'h0000807F);
    start_pass(2, 0, 1'b1, 64'd0);
    send_beat(127, pk8(127, -128, 0, 0));
    send_beat(127, pk8(127, -128, 0, 0));
    collect("t2_relu", 32'h0000007F);

    // 3: rounding and bias
    start_pass(1, 1, 1'b0, 64'd0);
    send_beat(5, pk8(1, 0, 0, 0));
    collect("t3_round_pos", 32'h00000003);
    start_pass(1, 1, 1'b0, 64'd0);
    send_beat(-5, pk8(1, 0, 0, 0));
    collect("t3_round_neg", 32'h000000FE);
    start_pass(1, 0, 1'b0, pk16(0, 0, 100, 0));
    send_beat(5, pk8(0, 0, 0, 0));
    collect("t3_bias", 32'h00640000);
    start_pass(0, 0, 1'b0, pk16(-7, 0, 0, 0));
    check_eq("t3_k0_fin_valid", {63'd0, out_valid}, 64'd0);
    tick();
    check_eq("t3_k0_out_valid", {63'd0, out_valid}, 64'd1);
    collect("t3_k0_data", 32'h000000F9);

    // 4: backpressure, ignored starts during OUT and on the handshake cycle
    start_pass(3, 0, 1'b0, 64'd0);
    send_beat(2, w_t1);
    send_beat(3, w_t1);
    send_beat(4, w_t1);
    wait_out();
    snap = out_data;
    check_eq("t4_snap", {32'd0, snap}, 64'h005AF709);
    for (int c = 0; c < 5; c++) begin
      if (c == 2) begin
        start = 1'b1;
        k_len = '0;
        bias  = pk16(50, 50, 50, 50);
      end else begin
        start = 1'b0;
      end
      tick();
      check_eq("t4_hold_valid", {63'd0, out_valid}, 64'd1);
      check_eq("t4_hold_data", {32'd0, out_data}, {32'd0, snap});
      check_eq("t4_hold_in_ready", {63'd0, in_ready}, 64'd0);
    end
    start     = 1'b1;
    k_len     = '0;
    out_ready = 1'b1;
    tick();
    start     = 1'b0;
    out_ready = 1'b0;
    check_eq("t4_hs_busy", {63'd0, busy}, 64'd0);
    tick();
    check_eq("t4_hs_start_ignored", {63'd0, busy}, 64'd0);
    start_pass(1, 0, 1'b0, 64'd0);
    send_beat(1, pk8(1, 2, 3, 4));
    collect("t4_next_pass", 32'h04030201);

    // 5: input gaps, then the same data gap-free
    start_pass(4, 0, 1'b0, 64'd0);
    idx = 0;
    for (int c = 0; c < 7; c++) begin
      in_valid = (pat[c] != 0);
      in_act   = (pat[c] != 0) ? acts[idx][DW-1:0] : 8'd99;
      in_wgt   = (pat[c] != 0) ? w_t5 : pk8(55, 55, 55, 55);
      rdy      = in_ready;
      tick();
      if ((pat[c] != 0) && rdy) begin
        idx++;
      end
    end
    in_valid = 1'b0;
    check_eq("t5_beats", 64'(idx), 64'd4);
    collect("t5_gapped", 32'h1EF6140A);
    start_pass(4, 0, 1'b0, 64'd0);
    for (int b = 0; b < 4; b++) begin
      send_beat(acts[b], w_t5);
    end
    collect("t5_nogap", 32'h1EF6140A);

    // 6: reset in the middle of accumulation
    start_pass(5, 0, 1'b0, 64'd0);
    send_beat(10, pk8(10, 10, 10, 10));
    send_beat(10, pk8(10, 10, 10, 10));
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("t6_rst_in_ready", {63'd0, in_ready}, 64'd0);
    check_eq("t6_rst_busy", {63'd0, busy}, 64'd0);
    check_eq("t6_rst_out_valid", {63'd0, out_valid}, 64'd0);
    check_eq("t6_rst_out_data", {32'd0, out_data}, 64'd0);
    #20;
    rst_n = 1'b1;
    tick();
    start_pass(1, 0, 1'b0, 64'd0);
    send_beat(2, pk8(1, 1, 1, 1));
    collect("t6_clean", 32'h02020202);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
